// File: rtl/ah_rr_requester_24.sv
// ah_rr_requester_24
// Per-channel pending-request tracker sitting in front of a 24-way round-robin
// arbiter. Each channel queues up to 7 outstanding requests, raises req while any
// are pending and retires one per accepted grant. It also reports each accepted
// grant, keeps a saturating grant total and three sticky error/health flags.

module ah_rr_requester_24 #(
    // Consecutive cycles with req!=0 and grant==0 before starve sets (2..1023).
    parameter int STARVE_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] push,
    input  logic [23:0] grant,
    output logic [23:0] req,
    output logic        done_vld,
    output logic [4:0]  done_idx,
    output logic [71:0] pend_cnt,
    output logic [15:0] grant_total,
    output logic        err_ovf,
    output logic        err_spur,
    output logic        starve
);

    localparam int         NCH   = 24;
    localparam logic [9:0] LIMIT = 10'(STARVE_LIMIT);

    logic [2:0]     pend_q [NCH];
    logic [2:0]     pend_d [NCH];
    logic [NCH-1:0] acc;
    logic           any_acc;
    logic [4:0]     acc_idx;
    logic           grant_nz;
    logic           grant_onehot;
    logic           spur_hit;
    logic           ovf_hit;
    logic [9:0]     starve_cnt_q;
    logic [9:0]     starve_cnt_d;
    logic           done_vld_q;
    logic [4:0]     done_idx_q;
    logic [15:0]    grant_total_q;
    logic           err_ovf_q;
    logic           err_spur_q;
    logic           starve_q;

    // Request vector and packed pending-count view, straight from the counters.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            req[i]              = (pend_q[i] != 3'd0);
            pend_cnt[3*i +: 3]  = pend_q[i];
        end
    end

    // Grant qualification: only a one-hot grant on a channel with work is accepted;
    // any other nonzero grant is spurious and leaves every counter alone.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant_nz     = |grant;
        grant_onehot = grant_nz && ((grant & (grant - 24'd1)) == 24'd0);
        acc_idx      = 5'd0;
        for (int i = 0; i < NCH; i++) begin
            acc[i] = grant_onehot && grant[i] && (pend_q[i] != 3'd0);
            if (acc[i]) begin
                acc_idx = 5'(i);
            end
        end
        any_acc  = |acc;
        spur_hit = grant_nz && !any_acc;
    end

    // Next pending count per channel; a push and an accepted grant cancel out,
    // which also means a full counter never overflows in that cycle.
    always_comb begin
        ovf_hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            pend_d[i] = pend_q[i];
            if (push[i] && !acc[i]) begin
                if (pend_q[i] == 3'd7) begin
                    ovf_hit = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 3'd1;
                end
            end else if (acc[i] && !push[i]) begin
                pend_d[i] = pend_q[i] - 3'd1;
            end
        end
    end

    // Starvation watchdog: counts request-without-grant cycles, saturating at the limit.
    always_comb begin
        if (grant_nz || (req == 24'd0)) begin
            starve_cnt_d = 10'd0;
        end else if (starve_cnt_q == LIMIT) begin
            starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = starve_cnt_q + 10'd1;
        end
    end

    // Pending counters.
    always_ff @(posedge clk) begin
        // NOTE: the counters are a small flop array, not RAM, so they take the reset like any other state.
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                pend_q[i] <= 3'd0;
            end
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            for (int i = 0; i < NCH; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    // Completion report, grant total, watchdog and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_vld_q    <= 1'b0;
            done_idx_q    <= 5'd0;
            grant_total_q <= 16'd0;
            starve_cnt_q  <= 10'd0;
            err_ovf_q     <= 1'b0;
            err_spur_q    <= 1'b0;
            starve_q      <= 1'b0;
        end else begin
            done_vld_q   <= any_acc;
            starve_cnt_q <= starve_cnt_d;
            if (any_acc) begin
                done_idx_q <= acc_idx;
                if (grant_total_q != 16'hFFFF) begin
                    grant_total_q <= grant_total_q + 16'd1;
                end
            end
            if (ovf_hit) begin
                err_ovf_q <= 1'b1;
            end
            if (spur_hit) begin
                err_spur_q <= 1'b1;
            end
            if (starve_cnt_d == LIMIT) begin
                starve_q <= 1'b1;
            end
        end
    end

    assign done_vld    = done_vld_q;
    assign done_idx    = done_idx_q;
    assign grant_total = grant_total_q;
    assign err_ovf     = err_ovf_q;
    assign err_spur    = err_spur_q;
    assign starve      = starve_q;

endmodule

// File: tb/tb_ah_rr_requester_24.sv
// Self-checking bench for ah_rr_requester_24: directed scenarios plus a
// round-robin arbiter model; expected completions go through a scoreboard queue.

module tb_ah_rr_requester_24;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] push = 24'd0;
    logic [23:0] grant_man = 24'd0;
    logic [23:0] grant_arb;
    logic [23:0] grant;
    logic        arb_en = 1'b0;
    logic [23:0] req;
    logic        done_vld;
    logic [4:0]  done_idx;
    logic [71:0] pend_cnt;
    logic [15:0] grant_total;
    logic        err_ovf;
    logic        err_spur;
    logic        starve;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int done_cnt[24];
    int rr_ptr;

    ah_rr_requester_24 #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .push(push), .grant(grant), .req(req),
        .done_vld(done_vld), .done_idx(done_idx), .pend_cnt(pend_cnt),
        .grant_total(grant_total), .err_ovf(err_ovf), .err_spur(err_spur),
        .starve(starve)
    );

    always #5 clk = ~clk;

    assign grant = arb_en ? grant_arb : grant_man;

    // Registered round-robin arbiter model; masks the channel it is granting
    // this cycle so the one-cycle lag never re-grants an emptied channel.
    always @(posedge clk) begin
        if (rst || !arb_en) begin
            grant_arb <= 24'd0;
            rr_ptr    <= 0;
        end else begin : arb
            logic [23:0] cand;
            int          pick;
            cand = req & ~grant_arb;
            pick = -1;
            for (int k = 0; k < 24; k++) begin
                if (pick < 0 && cand[(rr_ptr + k) % 24]) pick = (rr_ptr + k) % 24;
            end
            if (pick >= 0) begin
                grant_arb <= 24'd1 << pick;
                rr_ptr    <= (pick + 1) % 24;
                exp_q.push_back(pick);
            end else begin
                grant_arb <= 24'd0;
            end
        end
    end

    // Scoreboard monitor: every done_vld pulse must match the oldest expected channel.
    always @(negedge clk) begin
        if (done_vld === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected: done_vld=1 done_idx=%0d, required no pulse", done_idx);
            end else begin : pop
                int e;
                e = exp_q.pop_front();
                if (int'(done_idx) !== e) begin
                    failures++;
                    $display("FAIL done_idx: got %0d expected %0d", done_idx, e);
                end
            end
            if (done_idx < 5'd24) done_cnt[done_idx]++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pend_of(int ch);
        return pend_cnt[3*ch +: 3];
    endfunction

    task automatic do_reset;
        rst = 1'b1; push = 24'd0; grant_man = 24'd0; arb_en = 1'b0;
        tick;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 24; i++) done_cnt[i] = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        checks++; if (req !== 24'd0) begin failures++; $display("FAIL reset_req: got %h expected 0", req); end
        checks++; if (pend_cnt !== 72'd0) begin failures++; $display("FAIL reset_pend: got %h expected 0", pend_cnt); end
        checks++; if (done_vld !== 1'b0 || done_idx !== 5'd0) begin failures++; $display("FAIL reset_done: got vld=%b idx=%0d expected 0/0", done_vld, done_idx); end
        checks++; if (grant_total !== 16'd0) begin failures++; $display("FAIL reset_total: got %0d expected 0", grant_total); end
        checks++; if ({err_ovf, err_spur, starve} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {err_ovf, err_spur, starve}); end
    endtask

    task automatic test_single;
        do_reset;
        push = 24'd1 << 5;
        tick;
        push = 24'd0;
        checks++; if (req !== (24'd1 << 5)) begin failures++; $display("FAIL single_req: got %h expected %h", req, 24'd1 << 5); end
        grant_man = 24'd1 << 5;
        exp_q.push_back(5);
        tick;
        grant_man = 24'd0;
        checks++; if (done_vld !== 1'b1 || done_idx !== 5'd5) begin failures++; $display("FAIL single_done: got vld=%b idx=%0d expected 1/5", done_vld, done_idx); end
        checks++; if (pend_of(5) !== 3'd0 || req !== 24'd0) begin failures++; $display("FAIL single_pend: got pend=%0d req=%h expected 0/0", pend_of(5), req); end
        checks++; if (grant_total !== 16'd1) begin failures++; $display("FAIL single_total: got %0d expected 1", grant_total); end
        tick;
        checks++; if (done_vld !== 1'b0 || done_idx !== 5'd5) begin failures++; $display("FAIL single_hold: got vld=%b idx=%0d expected 0/5", done_vld, done_idx); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_overflow;
        do_reset;
        push = 24'd1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (k == 7) begin
                checks++; if (pend_of(0) !== 3'd7 || err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_seven: got pend=%0d ovf=%b expected 7/0", pend_of(0), err_ovf); end
            end
        end
        push = 24'd0;
        checks++; if (pend_of(0) !== 3'd7 || err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_eighth: got pend=%0d ovf=%b expected 7/1", pend_of(0), err_ovf); end
        push = 24'd1; grant_man = 24'd1;
        exp_q.push_back(0);
        tick;
        push = 24'd0; grant_man = 24'd0;
        checks++; if (pend_of(0) !== 3'd7) begin failures++; $display("FAIL ovf_pushgrant: got pend=%0d expected 7", pend_of(0)); end
        checks++; if (grant_total !== 16'd1 || err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_total: got total=%0d ovf=%b expected 1/1", grant_total, err_ovf); end
        tick;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_spurious;
        logic [71:0] exp_p;
        do_reset;
        push = 24'd1 << 4;
        tick;
        push = 24'd0;
        grant_man = 24'h000003;
        tick;
        grant_man = 24'd0;
        exp_p = 72'd0;
        exp_p[14:12] = 3'd1;
        checks++; if (err_spur !== 1'b1) begin failures++; $display("FAIL spur_multi: got err_spur=%b expected 1", err_spur); end
        checks++; if (pend_cnt !== exp_p || grant_total !== 16'd0) begin failures++; $display("FAIL spur_counters: got pend=%h total=%0d expected %h/0", pend_cnt, grant_total, exp_p); end
        tick;
        checks++; if (err_spur !== 1'b1) begin failures++; $display("FAIL spur_sticky: got err_spur=%b expected 1", err_spur); end
        do_reset;
        grant_man = 24'd1 << 9;
        tick;
        grant_man = 24'd0;
        checks++; if (err_spur !== 1'b1 || pend_cnt !== 72'd0) begin failures++; $display("FAIL spur_empty: got err_spur=%b pend=%h expected 1/0", err_spur, pend_cnt); end
        tick;
        checks++; if (done_vld !== 1'b0 || grant_total !== 16'd0) begin failures++; $display("FAIL spur_nodone: got vld=%b total=%0d expected 0/0", done_vld, grant_total); end
    endtask

    task automatic test_starve;
        do_reset;
        push = 24'd1 << 2;
        tick;
        push = 24'd0;
        checks++; if (starve !== 1'b0) begin failures++; $display("FAIL starve_early0: got %b expected 0", starve); end
        for (int c = 1; c <= 4; c++) begin
            tick;
            checks++; if (starve !== (c == 4)) begin failures++; $display("FAIL starve_cycle%0d: got %b expected %b", c, starve, c == 4); end
        end
        grant_man = 24'd1 << 2;
        exp_q.push_back(2);
        tick;
        grant_man = 24'd0;
        tick;
        checks++; if (starve !== 1'b1 || req !== 24'd0) begin failures++; $display("FAIL starve_sticky: got starve=%b req=%h expected 1/0", starve, req); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        push = (24'd1 << 1) | (24'd1 << 7);
        tick; tick;
        push = 24'd1 << 1;
        tick;
        push = 24'd0;
        checks++; if (pend_of(1) !== 3'd3 || pend_of(7) !== 3'd2) begin failures++; $display("FAIL mid_setup: got p1=%0d p7=%0d expected 3/2", pend_of(1), pend_of(7)); end
        rst = 1'b1; grant_man = 24'd1 << 1; push = 24'd1 << 3;
        tick;
        rst = 1'b0; grant_man = 24'd0; push = 24'd0;
        checks++; if (pend_cnt !== 72'd0 || req !== 24'd0) begin failures++; $display("FAIL mid_clear: got pend=%h req=%h expected 0/0", pend_cnt, req); end
        checks++; if (done_vld !== 1'b0 || grant_total !== 16'd0 || {err_ovf, err_spur, starve} !== 3'b000) begin failures++; $display("FAIL mid_status: got vld=%b total=%0d flags=%b expected 0/0/000", done_vld, grant_total, {err_ovf, err_spur, starve}); end
        push = 24'd1 << 3;
        tick;
        push = 24'd0;
        checks++; if (pend_of(3) !== 3'd1 || req !== (24'd1 << 3)) begin failures++; $display("FAIL mid_resume: got p3=%0d req=%h expected 1/%h", pend_of(3), req, 24'd1 << 3); end
    endtask

    task automatic test_arbiter;
        int n;
        int total;
        do_reset;
        push = 24'hFFFFFF;
        tick; tick;
        push = 24'd0;
        arb_en = 1'b1;
        for (n = 0; n < 400; n++) begin
            tick;
            if (pend_cnt == 72'd0 && grant == 24'd0) break;
        end
        checks++; if (n >= 400) begin failures++; $display("FAIL arb_timeout: got pend=%h after 400 cycles expected 0", pend_cnt); end
        arb_en = 1'b0;
        tick; tick;
        total = 0;
        for (int i = 0; i < 24; i++) begin
            total += done_cnt[i];
            checks++; if (done_cnt[i] != 2) begin failures++; $display("FAIL arb_ch%0d: got %0d pulses expected 2", i, done_cnt[i]); end
        end
        checks++; if (total != 48 || grant_total !== 16'd48) begin failures++; $display("FAIL arb_total: got pulses=%0d total=%0d expected 48/48", total, grant_total); end
        checks++; if ({err_ovf, err_spur, starve} !== 3'b000) begin failures++; $display("FAIL arb_flags: got %b expected 000", {err_ovf, err_spur, starve}); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL arb_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_overflow;
        test_spurious;
        test_starve;
        test_reset_mid;
        test_arbiter;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ah_rr_requester_24.md
AH_RR_REQUESTER_24 -- requirements
Module: ah_rr_requester_24

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 64, meaning the number of consecutive cycles with req!=0 and grant==0 before the starvation flag sets (legal range 2..1023).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port push, input, 24, meaning one-cycle pulses, each enqueueing one pending request on channel i.
REQ-005 SHALL have port grant, input, 24, meaning the registered grant vector from the 24-way round-robin arbiter.
REQ-006 SHALL have port req, output, 24, meaning the request vector driven to the arbiter.
REQ-007 SHALL have port done_vld, output, 1, meaning a one-cycle pulse reporting an accepted grant.
REQ-008 SHALL have port done_idx, output, 5, meaning the channel number (0..23) of the accepted grant, valid only with done_vld.
REQ-009 SHALL have port pend_cnt, output, 72, meaning the 24 per-channel 3-bit pending counts, channel i at bits [3i+2:3i].
REQ-010 SHALL have port grant_total, output, 16, meaning a saturating count of accepted grants.
REQ-011 SHALL have port err_ovf, output, 1, meaning sticky: a push was dropped.
REQ-012 SHALL have port err_spur, output, 1, meaning sticky: a grant arrived for a channel with zero pending, or grant was not one-hot/zero.
REQ-013 SHALL have port starve, output, 1, meaning sticky: the STARVE_LIMIT watchdog expired.

Function
REQ-014 SHALL keep, per channel, a 3-bit pending counter (0..7), registered.
REQ-015 SHALL drive req[i] combinationally as (pend[i] != 0); no other term.
REQ-016 SHALL treat grant[i] as accepted when grant is one-hot, bit i is set and pend[i] != 0; an accepted grant decrements pend[i] by 1 at the end of that cycle.
REQ-017 SHALL, on push[i] with no accepted grant[i], increment pend[i]; at pend[i]==7 the push is dropped, pend[i] stays 7 and err_ovf sets.
REQ-018 SHALL, on push[i] and accepted grant[i] in the same cycle, leave pend[i] unchanged (including at 7; no overflow).
REQ-019 SHALL, in the cycle after an accepted grant on channel i, assert done_vld=1 and done_idx=i (latency 1); otherwise done_vld=0 and done_idx holds its last value.
REQ-020 SHALL ignore a non-one-hot, non-zero grant: no counter changes, no done_vld, err_spur sets.
REQ-021 SHALL, for a one-hot grant on a channel with pend==0, change no counter, suppress done_vld and set err_spur.
REQ-022 SHALL increment grant_total by 1 per accepted grant and saturate at 16'hFFFF.
REQ-023 SHALL run a 10-bit starvation counter that increments each cycle where req!=0 and grant==0, and clears on any nonzero grant or when req==0; starve sets in the cycle the counter reaches STARVE_LIMIT, and the counter saturates there.
REQ-024 SHALL keep err_ovf, err_spur and starve set until rst; they are not self-clearing.
REQ-025 SHALL tolerate the arbiter's 1-cycle grant lag: req[i] remains high for the grant cycle, and no extra decrement occurs because acceptance requires pend[i]!=0.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, clear all pend counters, done_vld, done_idx, grant_total, the starvation counter, err_ovf, err_spur and starve to 0, so req=0.
REQ-027 SHALL let rst override all same-cycle push and grant activity, including mid-burst; the first post-reset cycle behaves as from power-up.

Verification
REQ-028 SHALL cover: push[5] single pulse -> req[5]=1 next cycle; grant=1<<5 one cycle later -> done_vld=1, done_idx=5 the cycle after; pend[5]=0, req[5]=0, grant_total=1.
REQ-029 SHALL cover: 8 push[0] pulses with no grant -> pend[0]=7, err_ovf=1 after the 8th; then a simultaneous push[0]+grant[0] -> pend[0] stays 7.
REQ-030 SHALL cover: grant=24'h000003 -> no done_vld, counters unchanged, err_spur=1; separately grant[9] with pend[9]=0 -> err_spur=1.
REQ-031 SHALL cover: STARVE_LIMIT=4, push[2], grant held 0 -> starve=1 exactly 4 cycles after req[2] rises; it stays 1 after a later grant.
REQ-032 SHALL cover: pend[1]=3, pend[7]=2, rst pulse -> all outputs 0 next cycle; pushes resume normally.
REQ-033 SHALL cover: connection to the 24-way round-robin arbiter with all channels pushed twice -> 48 done_vld pulses, each channel appearing exactly twice, final grant_total=48, all err flags 0.
